// File: rtl/multichannel_delay_ram_pkg.sv
// Shared types and constants for the multichannel delay RAM.
package multichannel_delay_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int PIPE_LAT = 2;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, registered read address, 1-cycle read latency.
module bram_sdp #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [ADDR_W-1:0] raddr_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      raddr_q <= raddr_i;
   end

   // Read after the address register, so a write from the previous cycle is visible.
   assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/multichannel_delay_ram.sv
// Per-channel programmable delay lines sharing one block RAM, cleared on reset and on flush.
module multichannel_delay_ram
   import multichannel_delay_ram_pkg::*;
#(
   parameter int  DATA_WIDTH = 24,
   parameter int  CHANNELS   = 4,
   parameter int  DEPTH_LOG2 = 10,
   localparam int CH_W       = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH_W-1:0]       in_channel,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [DEPTH_LOG2-1:0] delay,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_channel,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int AW = CH_W + DEPTH_LOG2;

   state_e                state_q, state_d;
   logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
   logic [DEPTH_LOG2-1:0] wptr_q [CHANNELS];
   logic                  accept;
   logic [DEPTH_LOG2-1:0] rd_off;

   logic                  ram_we;
   logic [AW-1:0]         ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [AW-1:0]         ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic                  vld_p1_q;
   logic [CH_W-1:0]       ch_p1_q;
   logic [DATA_WIDTH-1:0] data_p1_q;
   logic                  byp_p1_q;
   logic                  out_valid_q;
   logic [CH_W-1:0]       out_channel_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   assign in_ready = (state_q == RUN);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == '1) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) wptr_q[c] <= '0;
      end else if (state_q == RUN && flush) begin
         for (int c = 0; c < CHANNELS; c++) wptr_q[c] <= '0;
      end else if (accept) begin
         wptr_q[in_channel] <= wptr_q[in_channel] + DEPTH_LOG2'(1);
      end
   end

   // Stage p0: RAM write port is owned by the clear sweep in CLEAR, by acceptances in RUN.
   assign rd_off    = wptr_q[in_channel] - delay;
   assign ram_raddr = {in_channel, rd_off};

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      if (state_q == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_cnt_q;
      end else begin
         ram_we    = accept;
         ram_waddr = {in_channel, wptr_q[in_channel]};
         ram_wdata = in_data;
      end
   end

   bram_sdp #(
      .DATA_W (DATA_WIDTH),
      .ADDR_W (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // Stage p1: RAM read in flight; keep the input sample for the zero-delay bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         ch_p1_q  <= '0;
      end else begin
         vld_p1_q <= accept;
         if (accept) begin
            ch_p1_q <= in_channel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_p1_q <= in_data;
         byp_p1_q  <= (delay == '0);
      end
   end

   // Stage p2: output register, holds last sample when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_channel_q <= '0;
         out_data_q    <= '0;
      end else begin
         out_valid_q <= vld_p1_q;
         if (vld_p1_q) begin
            out_channel_q <= ch_p1_q;
            out_data_q    <= byp_p1_q ? data_p1_q : ram_rdata;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_channel = out_channel_q;
   assign out_data    = out_data_q;

endmodule

// File: tb/tb_multichannel_delay_ram.sv
// Directed bench for multichannel_delay_ram with default parameters.
module tb_multichannel_delay_ram;
   import multichannel_delay_ram_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_channel = '0;
   logic [23:0] in_data = '0;
   logic [9:0]  delay = '0;
   logic        out_valid;
   logic [1:0]  out_channel;
   logic [23:0] out_data;

   int checks = 0;
   int errors = 0;
   int n;

   logic [1:0]  s_ch  [16];
   logic [9:0]  s_dly [16];
   logic [23:0] s_dat [16];
   logic [23:0] s_exp [16];
   int          s_n;

   always #5 clk = ~clk;

   multichannel_delay_ram dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_channel  (in_channel),
      .in_data     (in_data),
      .delay       (delay),
      .out_valid   (out_valid),
      .out_channel (out_channel),
      .out_data    (out_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] ch, input logic [9:0] d,
                        input logic [23:0] dat, input logic fl);
      in_valid   = v;
      in_channel = ch;
      delay      = d;
      in_data    = dat;
      flush      = fl;
   endtask

   task automatic run_stream(input string tag);
      int j;
      for (int i = 0; i < s_n + PIPE_LAT - 1; i++) begin
         if (i < s_n) begin
            chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
            drive(1'b1, s_ch[i], s_dly[i], s_dat[i], 1'b0);
         end else begin
            drive(1'b0, 2'd0, 10'd0, 24'd0, 1'b0);
         end
         step();
         if (i >= PIPE_LAT - 1) begin
            j = i - (PIPE_LAT - 1);
            chk($sformatf("%s_vld%0d", tag, j), {31'b0, out_valid}, 32'd1);
            chk($sformatf("%s_ch%0d", tag, j), {30'b0, out_channel}, {30'b0, s_ch[j]});
            chk($sformatf("%s_dat%0d", tag, j), {8'b0, out_data}, {8'b0, s_exp[j]});
         end
      end
      step();
      chk({tag, "_idle_vld"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_hold"}, {8'b0, out_data}, {8'b0, s_exp[s_n-1]});
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_ovld", {31'b0, out_valid}, 32'd0);
      chk("rst_och", {30'b0, out_channel}, 32'd0);
      chk("rst_odat", {8'b0, out_data}, 32'd0);

      // Clear sweep after reset release, with in_valid held high
      in_valid = 1'b1;
      rst = 1'b0;
      n = 0;
      while (!in_ready && n < 5000) begin
         n++;
         step();
      end
      in_valid = 1'b0;
      chk("clear_len", n, 32'd4096);

      // Channel 0, delay 3
      s_n = 5;
      for (int i = 0; i < 5; i++) begin
         s_ch[i] = 2'd0; s_dly[i] = 10'd3; s_dat[i] = 24'(i + 1);
      end
      s_exp[0] = 24'd0; s_exp[1] = 24'd0; s_exp[2] = 24'd0; s_exp[3] = 24'd1; s_exp[4] = 24'd2;
      run_stream("d3");

      // Interleaved channel 1 (delay 1) and channel 2 (delay 2)
      s_n = 8;
      for (int i = 0; i < 8; i++) begin
         s_ch[i]  = (i % 2 == 0) ? 2'd1 : 2'd2;
         s_dly[i] = (i % 2 == 0) ? 10'd1 : 10'd2;
         s_dat[i] = 24'h10 + 24'(i);
      end
      s_exp[0] = 24'h0;  s_exp[1] = 24'h0;  s_exp[2] = 24'h10; s_exp[3] = 24'h0;
      s_exp[4] = 24'h12; s_exp[5] = 24'h11; s_exp[6] = 24'h14; s_exp[7] = 24'h13;
      run_stream("ilv");

      // Back-to-back on channel 1, delay 1: second read hits the previous cycle's write
      s_n = 2;
      s_ch[0] = 2'd1; s_dly[0] = 10'd1; s_dat[0] = 24'h20; s_exp[0] = 24'h16;
      s_ch[1] = 2'd1; s_dly[1] = 10'd1; s_dat[1] = 24'h21; s_exp[1] = 24'h20;
      run_stream("coll");

      // Channel 3, delay 0 bypass
      s_n = 1;
      s_ch[0] = 2'd3; s_dly[0] = 10'd0; s_dat[0] = 24'hABCDEF; s_exp[0] = 24'hABCDEF;
      run_stream("byp");

      // Channel 0, delay 1023, 1025 samples (channel 0 pointer starts at 5)
      for (int k = 1; k <= 1025; k++) begin
         drive(1'b1, 2'd0, 10'd1023, 24'(k), 1'b0);
         step();
         if (k == 2) chk("wrap_s1", {8'b0, out_data}, 32'd0);
         if (k == 1025) begin
            chk("wrap_s1024_vld", {31'b0, out_valid}, 32'd1);
            chk("wrap_s1024", {8'b0, out_data}, 32'd1);
         end
      end
      drive(1'b0, 2'd0, 10'd0, 24'd0, 1'b0);
      step();
      chk("wrap_s1025", {8'b0, out_data}, 32'd2);

      // Flush with two samples in flight, flush coinciding with the second acceptance
      drive(1'b1, 2'd1, 10'd0, 24'h55, 1'b0);
      step();
      drive(1'b1, 2'd2, 10'd1, 24'h66, 1'b1);
      step();
      chk("fl_ready0", {31'b0, in_ready}, 32'd0);
      chk("fl_a_vld", {31'b0, out_valid}, 32'd1);
      chk("fl_a_ch", {30'b0, out_channel}, 32'd1);
      chk("fl_a_dat", {8'b0, out_data}, 32'h55);
      n = 1;
      drive(1'b0, 2'd0, 10'd0, 24'd0, 1'b0);
      step();
      chk("fl_b_vld", {31'b0, out_valid}, 32'd1);
      chk("fl_b_ch", {30'b0, out_channel}, 32'd2);
      chk("fl_b_dat", {8'b0, out_data}, 32'h17);
      while (!in_ready && n < 5000) begin
         n++;
         step();
      end
      chk("fl_clear_len", n, 32'd4096);

      s_n = 1;
      s_ch[0] = 2'd0; s_dly[0] = 10'd5; s_dat[0] = 24'h7; s_exp[0] = 24'h0;
      run_stream("post_fl");

      // Asynchronous reset with an output present
      drive(1'b1, 2'd3, 10'd0, 24'h123, 1'b0);
      step();
      drive(1'b0, 2'd0, 10'd0, 24'd0, 1'b0);
      step();
      chk("pre_rst_vld", {31'b0, out_valid}, 32'd1);
      chk("pre_rst_dat", {8'b0, out_data}, 32'h123);
      rst = 1'b1;
      #2;
      chk("arst_ready", {31'b0, in_ready}, 32'd0);
      chk("arst_vld", {31'b0, out_valid}, 32'd0);
      chk("arst_ch", {30'b0, out_channel}, 32'd0);
      chk("arst_dat", {8'b0, out_data}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multichannel_delay_ram.md
MULTICHANNEL_DELAY_RAM -- requirements
Module: multichannel_delay_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sample width in bits.
REQ-002 Parameter CHANNELS, default 4, number of independent delay lines (power of two, >=2).
REQ-003 Parameter DEPTH_LOG2, default 10, log2 of per-channel buffer depth; DEPTH = 2**DEPTH_LOG2.
REQ-004 Derived CH_W = log2(CHANNELS); RAM address width = CH_W + DEPTH_LOG2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  request to zero all delay lines; sampled only in RUN.
REQ-008 in_valid  input  1  sample offered.
REQ-009 in_ready  output  1  block accepts a sample; high only in RUN.
REQ-010 in_channel  input  CH_W  channel of offered sample.
REQ-011 in_data  input  DATA_WIDTH  offered sample.
REQ-012 delay  input  DEPTH_LOG2  delay in samples of that channel, 0..DEPTH-1, sampled with in_data.
REQ-013 out_valid  output  1  delayed sample present, one-cycle pulse per accepted input.
REQ-014 out_channel  output  CH_W  channel of out_data.
REQ-015 out_data  output  DATA_WIDTH  sample written delay accepted-samples-of-that-channel earlier.

Function
REQ-016 States: CLEAR, RUN; acceptance = in_valid & in_ready.
REQ-017 CLEAR: write zero to one RAM address per cycle, counter 0 .. CHANNELS*DEPTH-1, then go to RUN the following cycle; in_ready low throughout.
REQ-018 RUN with flush=1 (with or without a simultaneous acceptance): any sample accepted in that cycle is processed normally; next cycle enters CLEAR with counter 0.
REQ-019 Per-channel write pointer wptr[c] (DEPTH_LOG2 bits); on acceptance, write in_data at {c, wptr[c]}, then wptr[c] increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-020 On acceptance, read address = {c, (wptr[c] - delay) mod DEPTH}; subtraction in DEPTH_LOG2 bits, wrap-around intended.
REQ-021 delay = 0: out_data equals the in_data of the same acceptance (bypass, no dependence on RAM read/write collision behaviour).
REQ-022 Latency fixed: out_valid high exactly 2 cycles after acceptance; out_channel = accepted in_channel.
REQ-023 Back-to-back acceptances (one per cycle, any channel mix) fully supported; outputs emerge in acceptance order, one per cycle.
REQ-024 Acceptance on channel c with delay d, d>=1, where write in cycle t-1 targeted the same address: the RAM's registered read returns the newly written value; no stale data.
REQ-025 No output back-pressure; out_valid/out_data held only one cycle, out_data holds last value when out_valid low.
REQ-026 Samples not yet written since last CLEAR read as zero.
REQ-027 Entering CLEAR resets all wptr[c] to 0; pipeline stages already in flight still emit their outputs.

Reset
REQ-028 rst asserted: state CLEAR, clear counter 0, all wptr 0, pipeline valids 0, out_valid 0, out_channel 0, out_data 0, in_ready 0, independent of clk.
REQ-029 After rst deasserts, CLEAR runs to completion (CHANNELS*DEPTH cycles) before in_ready rises; rst mid-CLEAR or mid-stream restarts from the reset state.

Structure
REQ-030 Package multichannel_delay_ram_pkg holds state enum (CLEAR, RUN) and the pipeline-latency constant (2).
REQ-031 RAM storage in one sub-module bram_sdp: parametrised simple dual-port block RAM, one write port, one read port with registered address, 1-cycle read latency, block-RAM style.
REQ-032 Write-port mux selects clear counter/zero in CLEAR, acceptance address/data in RUN.

Verification
REQ-033 Reset release, in_valid=1 -> in_ready low for exactly 4096 cycles (defaults), then high.
REQ-034 Ch0 delay=3, inputs 1,2,3,4,5 consecutive -> outputs 0,0,0,1,2 each 2 cycles after its input, out_channel=0.
REQ-035 Interleaved ch1 (delay 1) / ch2 (delay 2), data 0x10..0x17 alternating -> each channel sees only its own history; no cross-channel leakage.
REQ-036 Ch3 delay=0, data 0xABCDEF -> out_data 0xABCDEF 2 cycles later.
REQ-037 Ch0 delay=1023, write 1025 samples n=1..1025 -> sample 1024 outputs 1 and sample 1025 outputs 2 (pointer wrap).
REQ-038 Flush mid-stream with 2 samples in flight -> both outputs delivered, in_ready low 4096 cycles, subsequent delay=5 read returns 0.
